// File: rtl/sum_readout.sv
// Read-out stage for the half-sum / cos-sum accumulators: services READ (float add
// of the two sums) and CLEAR (zero request upstream) once the evaluation pipeline drains.
module sum_readout #(
    parameter int FLT_DATA_WIDTH = 32,
    parameter int N_WIDTH        = 2,
    parameter int STATE_WIDTH    = 3,
    parameter logic [N_WIDTH-1:0] CLEAR = 2'd0,
    parameter logic [N_WIDTH-1:0] GO    = 2'd1,
    parameter logic [N_WIDTH-1:0] READ  = 2'd2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clk_en,
    input  logic                      start,
    input  logic [N_WIDTH-1:0]        n,
    input  logic                      pipeline_empty,
    input  logic [FLT_DATA_WIDTH-1:0] half_sum,
    input  logic [FLT_DATA_WIDTH-1:0] cos_sum,
    output logic [FLT_DATA_WIDTH-1:0] result,
    output logic                      done,
    output logic                      clear_sums,
    output logic                      busy
);

    localparam logic [STATE_WIDTH-1:0] S_IDLE       = 3'd0;
    localparam logic [STATE_WIDTH-1:0] S_WAIT_EMPTY = 3'd1;
    localparam logic [STATE_WIDTH-1:0] S_ALIGN      = 3'd2;
    localparam logic [STATE_WIDTH-1:0] S_ADD        = 3'd3;
    localparam logic [STATE_WIDTH-1:0] S_NORM       = 3'd4;

    logic [STATE_WIDTH-1:0]    state, state_nxt;
    logic                      cmd_clear, cmd_clear_nxt;
    logic [FLT_DATA_WIDTH-1:0] op_a, op_b;
    logic [FLT_DATA_WIDTH-1:0] result_nxt;
    logic                      done_nxt, clear_nxt;
    logic                      cap_ops, ld_align, ld_sum;

    // Aligned operands: 24-bit significand plus 3 guard bits, larger magnitude first
    logic [26:0] big_sig, small_sig;
    logic [7:0]  exp_big;
    logic        sign_big, do_sub, special;
    logic [FLT_DATA_WIDTH-1:0] special_val;
    logic [27:0] sum;

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (rst)
            state <= S_IDLE;
        else if (clk_en)
            state <= state_nxt;
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_nxt     = state;
        cmd_clear_nxt = cmd_clear;
        case (state)
            S_IDLE: begin
                if (start) begin
                    case (n)
                        READ: begin
                            state_nxt     = S_WAIT_EMPTY;
                            cmd_clear_nxt = 1'b0;
                        end
                        CLEAR: begin
                            state_nxt     = S_WAIT_EMPTY;
                            cmd_clear_nxt = 1'b1;
                        end
                        GO:      state_nxt = S_IDLE;
                        default: state_nxt = S_IDLE;
                    endcase
                end
            end
            S_WAIT_EMPTY: begin
                if (pipeline_empty)
                    state_nxt = cmd_clear ? S_IDLE : S_ALIGN;
            end
            S_ALIGN: state_nxt = S_ADD;
            S_ADD:   state_nxt = S_NORM;
            S_NORM:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // ---------------- output / load-enable logic ----------------
    logic [FLT_DATA_WIDTH-1:0] norm_val;

    always_comb begin
        done_nxt   = 1'b0;
        clear_nxt  = 1'b0;
        result_nxt = result;
        cap_ops    = 1'b0;
        ld_align   = 1'b0;
        ld_sum     = 1'b0;
        case (state)
            S_WAIT_EMPTY: begin
                if (pipeline_empty) begin
                    if (cmd_clear) begin
                        clear_nxt  = 1'b1;
                        done_nxt   = 1'b1;
                        result_nxt = '0;
                    end else begin
                        cap_ops = 1'b1;
                    end
                end
            end
            S_ALIGN: ld_align = 1'b1;
            S_ADD:   ld_sum   = 1'b1;
            S_NORM: begin
                result_nxt = norm_val;
                done_nxt   = 1'b1;
            end
            default: ;
        endcase
    end

    assign busy = (state != S_IDLE);

    // ---------------- ALIGN datapath ----------------
    logic        a_zero, b_zero, a_larger;
    logic [30:0] mag_a, mag_b;
    logic [26:0] sig_a, sig_b, sig_l, sig_s, sig_s_sh;
    logic [7:0]  exp_l, exp_s, exp_diff;

    always_comb begin
        // Exponent 0 covers zero and denormals; both are flushed to zero
        a_zero   = (op_a[30:23] == 8'd0);
        b_zero   = (op_b[30:23] == 8'd0);
        mag_a    = a_zero ? 31'd0 : op_a[30:0];
        mag_b    = b_zero ? 31'd0 : op_b[30:0];
        sig_a    = a_zero ? 27'd0 : {1'b1, op_a[22:0], 3'b000};
        sig_b    = b_zero ? 27'd0 : {1'b1, op_b[22:0], 3'b000};
        a_larger = (mag_a >= mag_b);
        sig_l    = a_larger ? sig_a : sig_b;
        sig_s    = a_larger ? sig_b : sig_a;
        exp_l    = a_larger ? mag_a[30:23] : mag_b[30:23];
        exp_s    = a_larger ? mag_b[30:23] : mag_a[30:23];
        exp_diff = exp_l - exp_s;
        sig_s_sh = (exp_diff > 8'd25) ? 27'd0 : (sig_s >> exp_diff);
    end

    // ---------------- NORM datapath ----------------
    logic [4:0]  lz;
    logic [26:0] norm_sig;
    logic [9:0]  norm_exp;
    logic [22:0] mant;

    always_comb begin
        lz = 5'd27;
        for (int i = 0; i < 27; i++)
            if (sum[i]) lz = 5'(26 - i);
        if (sum[27]) begin
            norm_sig = sum[27:1];
            norm_exp = {2'b00, exp_big} + 10'd1;
        end else begin
            norm_sig = sum[26:0] << lz;
            norm_exp = {2'b00, exp_big} - {5'd0, lz};
        end
        mant = 23'(norm_sig[25:0] >> 3);

        if (special)
            norm_val = special_val;
        else if (!norm_sig[26])
            norm_val = '0;                                  // exact cancellation
        else if (norm_exp[9] || norm_exp == 10'd0)
            norm_val = '0;                                  // underflow flushes to +0
        else if (norm_exp >= 10'd255)
            norm_val = {sign_big, 8'hFF, 23'd0};
        else
            norm_val = {sign_big, norm_exp[7:0], mant};
    end

    // ---------------- registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            result      <= '0;
            done        <= 1'b0;
            clear_sums  <= 1'b0;
            cmd_clear   <= 1'b0;
            op_a        <= '0;
            op_b        <= '0;
            big_sig     <= '0;
            small_sig   <= '0;
            exp_big     <= '0;
            sign_big    <= 1'b0;
            do_sub      <= 1'b0;
            special     <= 1'b0;
            special_val <= '0;
            sum         <= '0;
        end else if (clk_en) begin
            result     <= result_nxt;
            done       <= done_nxt;
            clear_sums <= clear_nxt;
            cmd_clear  <= cmd_clear_nxt;
            if (cap_ops) begin
                op_a <= half_sum;
                op_b <= cos_sum;
            end
            if (ld_align) begin
                big_sig   <= sig_l;
                small_sig <= sig_s_sh;
                exp_big   <= exp_l;
                sign_big  <= a_larger ? op_a[31] : op_b[31];
                do_sub    <= op_a[31] ^ op_b[31];
                // Infinity/NaN operands bypass the adder; A takes precedence
                special     <= (op_a[30:23] == 8'hFF) || (op_b[30:23] == 8'hFF);
                special_val <= (op_a[30:23] == 8'hFF) ? op_a : op_b;
            end
            if (ld_sum)
                sum <= do_sub ? ({1'b0, big_sig} - {1'b0, small_sig})
                              : ({1'b0, big_sig} + {1'b0, small_sig});
        end
    end

endmodule

// File: tb/tb_sum_readout.sv
// Scoreboard bench for sum_readout: stimulus pushes expected result/clear/cycle,
// a negedge monitor pops and compares on every done pulse.
module tb_sum_readout;

    localparam logic [1:0] CLEAR = 2'd0;
    localparam logic [1:0] GO    = 2'd1;
    localparam logic [1:0] READ  = 2'd2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clk_en = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  n = READ;
    logic        pipeline_empty = 1'b1;
    logic [31:0] half_sum = '0;
    logic [31:0] cos_sum = '0;
    logic [31:0] result;
    logic        done, clear_sums, busy;

    sum_readout dut (
        .clk(clk), .rst(rst), .clk_en(clk_en), .start(start), .n(n),
        .pipeline_empty(pipeline_empty), .half_sum(half_sum), .cos_sum(cos_sum),
        .result(result), .done(done), .clear_sums(clear_sums), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic        clr;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          nvec = 0;
    int          nerr = 0;
    logic [31:0] last_res = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every enabled done pulse must match the oldest expectation
    always @(negedge clk) begin
        if (!rst && clk_en) begin
            if (done) begin
                nvec++;
                if (sb.size() == 0) begin
                    nerr++;
                    $display("FAIL unexpected_done: result=%h clear_sums=%b cyc=%0d", result, clear_sums, cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (result !== e.res || clear_sums !== e.clr || cyc != e.cyc) begin
                        nerr++;
                        $display("FAIL done_check: got result=%h clear=%b cyc=%0d, want result=%h clear=%b cyc=%0d",
                                 result, clear_sums, cyc, e.res, e.clr, e.cyc);
                    end
                end
            end else if (clear_sums) begin
                nvec++;
                nerr++;
                $display("FAIL clear_without_done: cyc=%0d", cyc);
            end
        end
    end

    task automatic step(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        nvec++;
        if (act !== want) begin
            nerr++;
            $display("FAIL %s: got %h, want %h", name, act, want);
        end
    endtask

    task automatic push(input logic [31:0] res, input logic clr, input int c);
        exp_t e;
        e.res = res;
        e.clr = clr;
        e.cyc = c;
        sb.push_back(e);
    endtask

    // Issue a READ with pipeline already empty; done expected 5 edges after issue point
    task automatic do_read(input logic [31:0] a, input logic [31:0] b, input logic [31:0] want);
        half_sum = a;
        cos_sum  = b;
        pipeline_empty = 1'b1;
        n     = READ;
        start = 1'b1;
        push(want, 1'b0, cyc + 5);
        last_res = want;
        step(1);
        start = 1'b0;
        step(6);
    endtask

    initial begin
        int k;

        step(3);
        chk("reset_result", result, 32'h0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_clear", {31'd0, clear_sums}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        step(1);

        // Basic READ with busy profile
        k = cyc;
        half_sum = 32'h3F800000;
        cos_sum  = 32'h40000000;
        n = READ;
        start = 1'b1;
        push(32'h40400000, 1'b0, k + 5);
        last_res = 32'h40400000;
        step(1);
        start = 1'b0;
        chk("busy_e0", {31'd0, busy}, 32'd1);
        step(3);
        chk("busy_e3", {31'd0, busy}, 32'd1);
        step(1);
        chk("busy_e4", {31'd0, busy}, 32'd0);
        step(2);

        // Directed arithmetic vectors
        do_read(32'h3FC00000, 32'hBFC00000, 32'h00000000);
        do_read(32'h00000000, 32'hC0A00000, 32'hC0A00000);
        do_read(32'h3F800000, 32'h33800000, 32'h3F800000);
        do_read(32'h3F800000, 32'h3F000000, 32'h3FC00000);
        do_read(32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000);
        do_read(32'h40400000, 32'hBF800000, 32'h40000000);
        do_read(32'h3FC00000, 32'hBFA00000, 32'h3E800000);
        do_read(32'h00800001, 32'h80800000, 32'h00000000);
        do_read(32'h3F800000, 32'hFF800000, 32'hFF800000);
        do_read(32'hFFC00000, 32'h7F800000, 32'hFFC00000);

        // Drain wait on READ: operands sampled when pipeline_empty rises
        k = cyc;
        half_sum = 32'h3F800000;
        cos_sum  = 32'h3F800000;
        pipeline_empty = 1'b0;
        n = READ;
        start = 1'b1;
        push(32'h40400000, 1'b0, k + 12);
        last_res = 32'h40400000;
        step(1);
        start = 1'b0;
        step(7);
        chk("drain_busy", {31'd0, busy}, 32'd1);
        half_sum = 32'h40000000;
        cos_sum  = 32'h3F800000;
        pipeline_empty = 1'b1;
        step(6);

        // Drain wait on CLEAR
        k = cyc;
        pipeline_empty = 1'b0;
        n = CLEAR;
        start = 1'b1;
        push(32'h0, 1'b1, k + 9);
        last_res = 32'h0;
        step(1);
        start = 1'b0;
        step(7);
        pipeline_empty = 1'b1;
        step(4);

        // Plain CLEAR after a non-zero READ
        do_read(32'h3F800000, 32'h3F000000, 32'h3FC00000);
        k = cyc;
        n = CLEAR;
        start = 1'b1;
        push(32'h0, 1'b1, k + 2);
        last_res = 32'h0;
        step(1);
        start = 1'b0;
        step(4);

        // GO and code 3 are ignored
        do_read(32'h3F800000, 32'h40000000, 32'h40400000);
        n = GO;
        start = 1'b1;
        step(1);
        start = 1'b0;
        chk("go_busy", {31'd0, busy}, 32'd0);
        n = 2'd3;
        start = 1'b1;
        step(1);
        start = 1'b0;
        chk("n3_busy", {31'd0, busy}, 32'd0);
        step(3);
        chk("go_result_hold", result, last_res);

        // start while busy is dropped
        k = cyc;
        half_sum = 32'h3F800000;
        cos_sum  = 32'h3F000000;
        n = READ;
        start = 1'b1;
        push(32'h3FC00000, 1'b0, k + 5);
        last_res = 32'h3FC00000;
        step(1);
        start = 1'b0;
        step(1);
        n = CLEAR;
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(5);
        chk("busy_start_result", result, 32'h3FC00000);

        // clk_en low for 3 cycles while in ADD
        k = cyc;
        half_sum = 32'h7F7FFFFF;
        cos_sum  = 32'h7F7FFFFF;
        n = READ;
        start = 1'b1;
        push(32'h7F800000, 1'b0, k + 8);
        last_res = 32'h7F800000;
        step(1);
        start = 1'b0;
        step(2);
        clk_en = 1'b0;
        step(3);
        clk_en = 1'b1;
        step(5);

        // Reset in ALIGN aborts without a done pulse
        half_sum = 32'h3F800000;
        cos_sum  = 32'h40000000;
        n = READ;
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(1);
        rst = 1'b1;
        step(1);
        chk("rst_align_busy", {31'd0, busy}, 32'd0);
        chk("rst_align_result", result, 32'h0);
        chk("rst_align_done", {31'd0, done}, 32'd0);
        rst = 1'b0;
        step(6);

        for (int i = 0; i < 50 && sb.size() != 0; i++) step(1);
        nvec++;
        if (sb.size() != 0) begin
            nerr++;
            $display("FAIL scoreboard_drain: %0d expected responses never seen, want 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
